gen_skid_buf: RTL and testbench
===============================

Name: gen_skid_buf

Overview:
- Two-entry valid/ready register slice that breaks the combinational ready path between a producer and a consumer.
- Holds at most two words: a main register, which is the output, and a skid register.
- All storage is built from enable flops with asynchronous active-low reset.
- Sits between pipeline stages, directly upstream of the stage's enable-flop state, and feeds it registered data and a valid qualifier.

Parameters:
- DW, 32, data width in bits.
- rstValue, {DW{1'b0}}, reset value of both data registers.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RSTn  input  1  asynchronous active-low reset.
- flush  input  1  synchronous discard of all held entries.
- enq_valid  input  1  producer has data.
- enq_ready  output  1  buffer can accept; driven only from registers.
- enq_data  input  DW  producer data.
- deq_valid  output  1  main register holds valid data.
- deq_ready  input  1  consumer accepts.
- deq_data  output  DW  main register contents.

Behaviour:
- Interface: one clock CLK; reset RSTn is asynchronous and active-low.
- Fire definitions: enq_fire = enq_valid & enq_ready; deq_fire = deq_valid & deq_ready.
- Reset (RSTn=0, takes effect immediately, no clock needed):
  - state=EMPTY; main and skid data regs = rstValue.
  - deq_valid=0, enq_ready=1, deq_data=rstValue.
- States: EMPTY (no entries), BUSY (main valid), FULL (main and skid valid).
- Output decode (registered only, no input-to-output combinational path):
  - deq_valid = (state != EMPTY).
  - enq_ready = (state != FULL).
  - deq_data = main register.
- Transitions at clock edge when flush=0:
  - EMPTY: enq_fire -> BUSY, main<=enq_data; else stay.
  - BUSY, enq_fire & deq_fire: stay BUSY, main<=enq_data.
  - BUSY, enq_fire only: -> FULL, skid<=enq_data, main unchanged.
  - BUSY, deq_fire only: -> EMPTY.
  - BUSY, neither: hold.
  - FULL, deq_fire: -> BUSY, main<=skid. enq_fire is impossible here since enq_ready=0.
  - FULL, no deq_fire: hold; both registers unchanged.
- Flush:
  - flush=1 at an edge: state<=EMPTY regardless of fires. Any enq_fire in that cycle is dropped.
  - Data registers need not be cleared. deq_data after flush is don't-care while deq_valid=0.
  - A deq_fire in a flush cycle still counts as consumed by the consumer. The buffer does not re-present that word.
- Latency: enq to deq_valid is exactly 1 cycle.
- Throughput: 1 word/cycle sustained when deq_ready is held high.
- Ordering: strict FIFO order; no data loss or duplication except on flush.
- Stability: while deq_valid=1 and deq_ready=0, deq_data and deq_valid hold stable.
- Enables: data registers load only on the enables listed above; otherwise they hold. Implemented as gen_dffren instances plus a 2-bit state register.
- Reset mid-operation: all held entries are lost immediately; outputs take their reset values asynchronously.

Test Plan:
- Reset, then single word:
  - Assert RSTn=0 mid-traffic -> deq_valid=0, enq_ready=1, deq_data=0 immediately.
  - Release reset, enq 0xA5A5A5A5 -> deq_valid=1 next cycle with deq_data=0xA5A5A5A5.
- Streaming: deq_ready=1, enq_valid=1, enqueue 0..15 back-to-back -> deq emits 0..15 on consecutive cycles, 1-cycle latency, enq_ready never drops.
- Backpressure fill:
  - deq_ready=0, enqueue 0x11 then 0x22 -> state FULL, enq_ready=0, deq_data=0x11 held.
  - Offered 0x33 is not accepted.
  - Then deq_ready=1 -> outputs 0x11, 0x22, 0x33 in order.
- Simultaneous enq/deq in BUSY: main=0x44, enq 0x55 with deq_ready=1 -> 0x44 consumed, next cycle deq_data=0x55, state BUSY.
- Flush:
  - In FULL (0x66, 0x77), assert flush with enq_valid=0 -> next cycle deq_valid=0, enq_ready=1.
  - Flush in BUSY with enq_fire of 0x88 -> 0x88 dropped, deq_valid=0 next cycle.
- Random scoreboard: 10k cycles, random enq_valid/deq_ready/flush (5%), compared against a reference queue model.
  - No loss or duplication outside flush.
  - deq_data stable under stall.
  - enq_ready is never 1 while holding 2 entries.

Source files
------------

// File: rtl/gen_dffren.sv
// Enable flop with asynchronous active-low reset: the storage primitive of
// the skid buffer's data path.
module gen_dffren #(
  parameter int unsigned    W   = 32,
  parameter logic [W-1:0]   RST = {W{1'b0}}
) (
  input  logic         CLK,
  input  logic         RSTn,
  input  logic         i_en,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  // Load on enable, otherwise hold; reset value applies without a clock.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values of its inputs, independent of block evaluation order.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_q <= RST;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/gen_skid_buf.sv
// Two-entry valid/ready register slice. The main register drives the
// consumer; the skid register catches the one word that arrives in the cycle
// the consumer stalls. enq_ready comes from state only, so no ready path
// runs combinationally from consumer to producer.
module gen_skid_buf #(
  parameter int unsigned   DW       = 32,
  parameter logic [DW-1:0] rstValue = {DW{1'b0}}
) (
  input  logic          CLK,
  input  logic          RSTn,
  input  logic          flush,
  input  logic          enq_valid,
  output logic          enq_ready,
  input  logic [DW-1:0] enq_data,
  output logic          deq_valid,
  input  logic          deq_ready,
  output logic [DW-1:0] deq_data
);

  typedef enum logic [1:0] {
    EMPTY = 2'b00,  // no entries
    BUSY  = 2'b01,  // main valid
    FULL  = 2'b10   // main and skid valid
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  logic          w_enq_fire;
  logic          w_deq_fire;
  logic          w_main_en;
  logic          w_skid_en;
  logic [DW-1:0] w_main_d;
  logic [DW-1:0] w_main_q;
  logic [DW-1:0] w_skid_q;

  // Outputs decode from state and the main register only.
  assign deq_valid  = (r_state != EMPTY);
  assign enq_ready  = (r_state != FULL);
  assign deq_data   = w_main_q;

  assign w_enq_fire = enq_valid & enq_ready;
  assign w_deq_fire = deq_valid & deq_ready;

  // State register.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and data-register enables. A flush empties the buffer and
  // suppresses every load, so a word offered in that cycle is dropped.
  // NOTE: every output of this block is given a default first; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_main_en   = 1'b0;
    w_skid_en   = 1'b0;
    w_main_d    = enq_data;
    if (flush) begin
      w_state_nxt = EMPTY;
    end else begin
      unique case (r_state)
        EMPTY: begin
          if (w_enq_fire) begin
            w_state_nxt = BUSY;
            w_main_en   = 1'b1;
          end
        end
        BUSY: begin
          if (w_enq_fire && w_deq_fire) begin
            w_main_en   = 1'b1;
          end else if (w_enq_fire) begin
            w_state_nxt = FULL;
            w_skid_en   = 1'b1;
          end else if (w_deq_fire) begin
            w_state_nxt = EMPTY;
          end
        end
        FULL: begin
          // enq_ready is low here, so only the consumer can move data.
          if (w_deq_fire) begin
            w_state_nxt = BUSY;
            w_main_en   = 1'b1;
            w_main_d    = w_skid_q;
          end
        end
        default: begin
          w_state_nxt = EMPTY;
        end
      endcase
    end
  end

  // Main register: the word presented to the consumer.
  // NOTE: the data registers are reset to a known value so deq_data is
  // defined straight out of reset; validity is carried by r_state alone.
  gen_dffren #(
    .W   (DW),
    .RST (rstValue)
  ) u_main (
    .CLK  (CLK),
    .RSTn (RSTn),
    .i_en (w_main_en),
    .i_d  (w_main_d),
    .o_q  (w_main_q)
  );

  // Skid register: second entry, filled only when main is stalled.
  gen_dffren #(
    .W   (DW),
    .RST (rstValue)
  ) u_skid (
    .CLK  (CLK),
    .RSTn (RSTn),
    .i_en (w_skid_en),
    .i_d  (enq_data),
    .o_q  (w_skid_q)
  );

endmodule

// File: tb/tb_gen_skid_buf.sv
// Directed and randomized checks for gen_skid_buf against hand-computed
// values and a two-entry queue model.
module tb_gen_skid_buf;

  localparam int DW = 32;

  logic          CLK;
  logic          RSTn;
  logic          flush;
  logic          enq_valid;
  logic          enq_ready;
  logic [DW-1:0] enq_data;
  logic          deq_valid;
  logic          deq_ready;
  logic [DW-1:0] deq_data;

  int checks = 0;
  int errors = 0;

  gen_skid_buf #(
    .DW       (DW),
    .rstValue ({DW{1'b0}})
  ) dut (
    .CLK       (CLK),
    .RSTn      (RSTn),
    .flush     (flush),
    .enq_valid (enq_valid),
    .enq_ready (enq_ready),
    .enq_data  (enq_data),
    .deq_valid (deq_valid),
    .deq_ready (deq_ready),
    .deq_data  (deq_data)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [DW-1:0] obs,
                       input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  logic [DW-1:0] q[$];
  logic          exp_valid;
  logic          exp_ready;
  logic          m_enq_fire;
  logic          m_deq_fire;
  logic          prev_stall;
  logic [DW-1:0] prev_data;

  initial begin
    RSTn      = 1'b0;
    flush     = 1'b0;
    enq_valid = 1'b0;
    enq_data  = '0;
    deq_ready = 1'b0;
    #3;
    check("rst_deq_valid", {31'd0, deq_valid}, 32'd0);
    check("rst_enq_ready", {31'd0, enq_ready}, 32'd1);
    check("rst_deq_data",  deq_data, 32'd0);
    tick();
    tick();
    RSTn = 1'b1;

    // Fill to FULL, then reset asynchronously between edges.
    enq_valid = 1'b1;
    enq_data  = 32'h1234_5678;
    tick();
    enq_data  = 32'h9ABC_DEF0;
    tick();
    check("pre_rst_full_ready", {31'd0, enq_ready}, 32'd0);
    check("pre_rst_data", deq_data, 32'h1234_5678);
    #2;
    RSTn = 1'b0;
    #1;
    check("async_rst_deq_valid", {31'd0, deq_valid}, 32'd0);
    check("async_rst_enq_ready", {31'd0, enq_ready}, 32'd1);
    check("async_rst_deq_data",  deq_data, 32'd0);
    enq_valid = 1'b0;
    tick();
    RSTn = 1'b1;

    // Single word, one-cycle latency.
    enq_valid = 1'b1;
    enq_data  = 32'hA5A5_A5A5;
    check("single_pre_valid", {31'd0, deq_valid}, 32'd0);
    tick();
    enq_valid = 1'b0;
    check("single_valid", {31'd0, deq_valid}, 32'd1);
    check("single_data", deq_data, 32'hA5A5_A5A5);
    deq_ready = 1'b1;
    tick();
    check("single_drained", {31'd0, deq_valid}, 32'd0);

    // Streaming 0..15 back-to-back.
    enq_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      enq_data = 32'(i);
      tick();
      check($sformatf("stream_ready_%0d", i), {31'd0, enq_ready}, 32'd1);
      check($sformatf("stream_valid_%0d", i), {31'd0, deq_valid}, 32'd1);
      check($sformatf("stream_data_%0d", i), deq_data, 32'(i));
    end
    enq_valid = 1'b0;
    tick();
    check("stream_drained", {31'd0, deq_valid}, 32'd0);

    // Backpressure fill, rejected offer, then drain in order.
    deq_ready = 1'b0;
    enq_valid = 1'b1;
    enq_data  = 32'h11;
    tick();
    enq_data  = 32'h22;
    tick();
    check("bp_full_ready", {31'd0, enq_ready}, 32'd0);
    check("bp_full_data", deq_data, 32'h11);
    enq_data  = 32'h33;
    tick();
    check("bp_reject_ready", {31'd0, enq_ready}, 32'd0);
    check("bp_hold_data", deq_data, 32'h11);
    deq_ready = 1'b1;
    tick();
    check("bp_out2_data", deq_data, 32'h22);
    check("bp_out2_ready", {31'd0, enq_ready}, 32'd1);
    tick();
    enq_valid = 1'b0;
    check("bp_out3_data", deq_data, 32'h33);
    check("bp_out3_valid", {31'd0, deq_valid}, 32'd1);
    tick();
    check("bp_drained", {31'd0, deq_valid}, 32'd0);

    // Simultaneous enq and deq in BUSY.
    deq_ready = 1'b0;
    enq_valid = 1'b1;
    enq_data  = 32'h44;
    tick();
    check("sim_main", deq_data, 32'h44);
    enq_data  = 32'h55;
    deq_ready = 1'b1;
    tick();
    enq_valid = 1'b0;
    check("sim_data", deq_data, 32'h55);
    check("sim_valid", {31'd0, deq_valid}, 32'd1);
    check("sim_busy_ready", {31'd0, enq_ready}, 32'd1);
    tick();
    check("sim_drained", {31'd0, deq_valid}, 32'd0);

    // Flush in FULL.
    deq_ready = 1'b0;
    enq_valid = 1'b1;
    enq_data  = 32'h66;
    tick();
    enq_data  = 32'h77;
    tick();
    check("flfull_pre_ready", {31'd0, enq_ready}, 32'd0);
    enq_valid = 1'b0;
    flush     = 1'b1;
    tick();
    flush     = 1'b0;
    check("flfull_valid", {31'd0, deq_valid}, 32'd0);
    check("flfull_ready", {31'd0, enq_ready}, 32'd1);
    tick();
    check("flfull_stays_empty", {31'd0, deq_valid}, 32'd0);

    // Flush in BUSY while 0x88 is offered and accepted-looking.
    enq_valid = 1'b1;
    enq_data  = 32'h80;
    tick();
    check("flbusy_pre", deq_data, 32'h80);
    enq_data  = 32'h88;
    flush     = 1'b1;
    tick();
    flush     = 1'b0;
    enq_valid = 1'b0;
    check("flbusy_valid", {31'd0, deq_valid}, 32'd0);
    tick();
    check("flbusy_dropped", {31'd0, deq_valid}, 32'd0);

    // Random traffic against a queue model; buffer is empty here.
    q.delete();
    prev_stall = 1'b0;
    prev_data  = '0;
    for (int c = 0; c < 10000; c++) begin
      exp_valid = (q.size() > 0);
      exp_ready = (q.size() < 2);
      check("rnd_deq_valid", {31'd0, deq_valid}, {31'd0, exp_valid});
      check("rnd_enq_ready", {31'd0, enq_ready}, {31'd0, exp_ready});
      if (exp_valid) check("rnd_deq_data", deq_data, q[0]);
      if (prev_stall) check("rnd_stall_stable", deq_data, prev_data);

      enq_valid = 1'($urandom_range(0, 1));
      deq_ready = 1'($urandom_range(0, 1));
      enq_data  = $urandom;
      flush     = ($urandom_range(0, 99) < 5);

      m_enq_fire = enq_valid & exp_ready;
      m_deq_fire = exp_valid & deq_ready;
      prev_stall = exp_valid & ~deq_ready & ~flush;
      prev_data  = exp_valid ? q[0] : '0;
      if (flush) begin
        q.delete();
      end else begin
        if (m_deq_fire) void'(q.pop_front());
        if (m_enq_fire) q.push_back(enq_data);
      end
      tick();
    end
    enq_valid = 1'b0;
    flush     = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
